// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: round-robin arbitration between two requesters,
// alignment checks, load extension and read-modify-write for sub-word stores.
module dmem_access_ctrl #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  req_valid,
   output logic [1:0]                  req_ready,
   input  logic [1:0]                  req_we,
   input  logic [5:0]                  req_funct3,
   input  logic [2*(DM_ADDRESS+2)-1:0] req_addr,
   input  logic [2*DATA_W-1:0]         req_wdata,
   output logic [1:0]                  rsp_valid,
   output logic                        rsp_err,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [DM_ADDRESS-1:0]       mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata
);

   localparam int AW = DM_ADDRESS + 2;

   typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

   state_t              state;
   logic                last_grant;
   logic                port_q;
   logic                we_q;
   logic [2:0]          f3_q;
   logic [1:0]          lane_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                xfer;
   logic                sel;
   logic                sel_we;
   logic [2:0]          sel_f3;
   logic [AW-1:0]       sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   function automatic logic [1:0] grant(input logic [1:0] valid, input logic last);
      if (valid == 2'b11)
         return last ? 2'b01 : 2'b10;
      return valid;
   endfunction

   function automatic logic is_bad(input logic we, input logic [2:0] f3, input logic [1:0] lane);
      logic legal;
      logic mis;
      if (we)
         legal = f3 inside {3'b000, 3'b001, 3'b010};
      else
         legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      mis = ((f3[1:0] == 2'b01) && lane[0]) || ((f3 == 3'b010) && (lane != 2'b00));
      return !legal || mis;
   endfunction

   function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                     input logic [DATA_W-1:0] word);
      logic signed [7:0]        b;
      logic signed [15:0]       h;
      logic signed [DATA_W-1:0] ext;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  ext = b;
         3'b001:  ext = h;
         3'b100:  ext = {{(DATA_W-8){1'b0}}, b};
         3'b101:  ext = {{(DATA_W-16){1'b0}}, h};
         default: ext = word;
      endcase
      return ext;
   endfunction

   function automatic logic [DATA_W-1:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                                     input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] wdata);
      logic [DATA_W-1:0] word;
      word = old;
      case (f3[1:0])
         2'b00:   word[{lane, 3'b000} +: 8]    = wdata[7:0];
         2'b01:   word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: word = wdata;
      endcase
      return word;
   endfunction

   // The granted port is the one whose ready bit is set; ready is one-hot or zero.
   assign xfer      = (state == IDLE) && ((req_valid & req_ready) != 2'b00);
   assign sel       = req_ready[1];
   assign sel_we    = req_we[sel];
   assign sel_f3    = sel ? req_funct3[5:3] : req_funct3[2:0];
   assign sel_addr  = sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
   assign sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (xfer) begin
         f3_q    <= sel_f3;
         lane_q  <= sel_addr[1:0];
         wdata_q <= sel_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         port_q     <= 1'b0;
         we_q       <= 1'b0;
         req_ready  <= 2'b00;
         rsp_valid  <= 2'b00;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         req_ready <= 2'b00;
         rsp_valid <= 2'b00;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         case (state)
            IDLE: begin
               if (xfer) begin
                  port_q     <= sel;
                  we_q       <= sel_we;
                  last_grant <= sel;
                  mem_addr   <= sel_addr[AW-1:2];
                  if (is_bad(sel_we, sel_f3, sel_addr[1:0])) begin
                     state     <= RESP;
                     rsp_valid <= sel ? 2'b10 : 2'b01;
                     rsp_err   <= 1'b1;
                  end else if (!sel_we || (sel_f3[1:0] != 2'b10)) begin
                     state  <= RD;
                     mem_en <= 1'b1;
                  end else begin
                     state     <= WR;
                     mem_en    <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_wdata <= sel_wdata;
                  end
               end else begin
                  req_ready <= grant(req_valid, last_grant);
               end
            end
            RD: state <= RD_WAIT;
            // Read data is on mem_rdata now: either finish the load or build the merged word.
            RD_WAIT: begin
               if (we_q) begin
                  state     <= WR;
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_wdata <= store_merge(f3_q, lane_q, mem_rdata, wdata_q);
               end else begin
                  state     <= RESP;
                  rsp_valid <= port_q ? 2'b10 : 2'b01;
                  rsp_rdata <= load_extend(f3_q, lane_q, mem_rdata);
               end
            end
            WR: begin
               state     <= RESP;
               rsp_valid <= port_q ? 2'b10 : 2'b01;
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= grant(req_valid, last_grant);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural SRAM and a response scoreboard.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [5:0]  req_funct3;
   logic [21:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   dmem_access_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  vld;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          xcyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          vectors = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [8:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;

   logic [31:0] mem [0:511];
   logic        poke_en = 1'b0;
   logic [8:0]  poke_addr = '0;
   logic [31:0] poke_data = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (poke_en)
         mem[poke_addr] <= poke_data;
      else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   always @(negedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
         end else begin
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid !== 2'b00) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_port", 32'(rsp_valid), 32'(mon_e.vld));
            chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            chk("rsp_latency", 32'(cyc - mon_e.xcyc), 32'(mon_e.lat));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic poke(input logic [8:0] a, input logic [31:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic set_req(input int p, input logic we, input logic [2:0] f3,
                          input logic [10:0] addr, input logic [31:0] wd);
      req_we[p]             = we;
      req_funct3[p*3 +: 3]  = f3;
      req_addr[p*11 +: 11]  = addr;
      req_wdata[p*32 +: 32] = wd;
   endtask

   // Drives one request and returns just after its transfer edge.
   task automatic issue(input int p, input logic we, input logic [2:0] f3, input logic [10:0] addr,
                        input logic [31:0] wd, input logic exp_rsp, input logic err,
                        input logic [31:0] rd, input int lat);
      bit   got;
      exp_t e;
      got = 1'b0;
      @(negedge clk);
      set_req(p, we, f3, addr, wd);
      req_valid[p] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[p]) begin
            got = 1'b1;
            break;
         end
      end
      chk("ready_seen", 32'(got), 32'd1);
      if (got) begin
         chk("ready_exclusive", 32'(req_ready), 32'(1 << p));
         if (exp_rsp) begin
            e.vld = 2'(1 << p); e.err = err; e.rdata = rd; e.lat = lat; e.xcyc = cyc;
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      req_valid[p] = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      chk("rsp_pending", 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic access(input string tag, input int p, input logic we, input logic [2:0] f3,
                         input logic [10:0] addr, input logic [31:0] wd, input logic err,
                         input logic [31:0] rd, input int lat, input int n_rd, input int n_wr);
      int r0;
      int w0;
      r0 = rd_cnt;
      w0 = wr_cnt;
      issue(p, we, f3, addr, wd, 1'b1, err, rd, lat);
      wait_done();
      chk({tag, "_reads"}, 32'(rd_cnt - r0), 32'(n_rd));
      chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(n_wr));
   endtask

   function automatic logic [31:0] arb_val(input int p, input int k);
      return 32'hA000_0000 | 32'(p << 8) | 32'(k);
   endfunction

   // Both ports hold valid continuously; grants must alternate starting at port 0.
   task automatic arb_run(input int n);
      int   idx[2];
      int   nx;
      int   p;
      exp_t e;
      idx[0] = 0; idx[1] = 0; nx = 0;
      @(negedge clk);
      for (int q = 0; q < 2; q++) set_req(q, 1'b0, 3'b010, 11'((32 + q*8) * 4), 32'd0);
      req_valid = 2'b11;
      for (int i = 0; i < 400 && nx < 2*n; i++) begin
         @(negedge clk);
         if ((req_ready & req_valid) != 2'b00) begin
            p = req_ready[1] ? 1 : 0;
            chk("grant_order", 32'(p), 32'(nx % 2));
            e.vld = 2'(1 << p); e.err = 1'b0; e.rdata = arb_val(p, idx[p]); e.lat = 3; e.xcyc = cyc;
            sb.push_back(e);
            nx++;
            idx[p]++;
            @(posedge clk);
            #1;
            if (idx[p] < n) set_req(p, 1'b0, 3'b010, 11'((32 + p*8 + idx[p]) * 4), 32'd0);
            else req_valid[p] = 1'b0;
         end
      end
      req_valid = 2'b00;
      chk("arb_transfers", 32'(nx), 32'(2*n));
      wait_done();
   endtask

   initial begin
      int w0;
      rst_n = 1'b0;
      req_valid = '0; req_we = '0; req_funct3 = '0; req_addr = '0; req_wdata = '0;

      poke(9'd5, 32'h8080_F081);
      poke(9'd2, 32'h1122_3344);
      poke(9'd7, 32'h5566_7788);
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < 6; k++) poke(9'(32 + p*8 + k), arb_val(p, k));

      @(negedge clk);
      chk("reset_ctrl", 32'({req_ready, rsp_valid, rsp_err, mem_en, mem_we}), 32'd0);
      chk("reset_rdata", rsp_rdata, 32'd0);
      chk("reset_maddr", 32'(mem_addr), 32'd0);
      chk("reset_mwdata", mem_wdata, 32'd0);
      rst_n = 1'b1;

      // Sub-word loads with sign/zero extension.
      access("lb",  0, 1'b0, 3'b000, 11'h14, 32'd0, 1'b0, 32'hFFFF_FF81, 3, 1, 0);
      access("lbu", 0, 1'b0, 3'b100, 11'h15, 32'd0, 1'b0, 32'h0000_00F0, 3, 1, 0);
      access("lh",  0, 1'b0, 3'b001, 11'h16, 32'd0, 1'b0, 32'hFFFF_8080, 3, 1, 0);
      access("lhu", 0, 1'b0, 3'b101, 11'h16, 32'd0, 1'b0, 32'h0000_8080, 3, 1, 0);

      // Read-modify-write stores on port 1.
      access("sb", 1, 1'b1, 3'b000, 11'h09, 32'h5A5A_5AAB, 1'b0, 32'd0, 4, 1, 1);
      chk("sb_wr_addr", 32'(wr_addr), 32'd2);
      chk("sb_wr_data", wr_data, 32'h1122_AB44);
      access("sh", 1, 1'b1, 3'b001, 11'h0A, 32'h7777_BEEF, 1'b0, 32'd0, 4, 1, 1);
      chk("sh_wr_data", wr_data, 32'hBEEF_AB44);
      chk("sh_mem", mem[2], 32'hBEEF_AB44);

      // Full-word store then load back.
      access("sw", 0, 1'b1, 3'b010, 11'h0C, 32'hDEAD_BEEF, 1'b0, 32'd0, 2, 0, 1);
      chk("sw_wr_addr", 32'(wr_addr), 32'd3);
      access("lw", 0, 1'b0, 3'b010, 11'h0C, 32'd0, 1'b0, 32'hDEAD_BEEF, 3, 1, 0);

      // Misaligned and illegal encodings.
      access("lw_mis",  0, 1'b0, 3'b010, 11'h0E, 32'd0, 1'b1, 32'd0, 1, 0, 0);
      access("sh_mis",  1, 1'b1, 3'b001, 11'h03, 32'hFFFF_FFFF, 1'b1, 32'd0, 1, 0, 0);
      access("ld_ill",  0, 1'b0, 3'b011, 11'h10, 32'd0, 1'b1, 32'd0, 1, 0, 0);
      access("st_ill",  1, 1'b1, 3'b100, 11'h10, 32'h1234_5678, 1'b1, 32'd0, 1, 0, 0);

      arb_run(6);

      // Reset during the write phase of an sb on port 0.
      w0 = wr_cnt;
      issue(0, 1'b1, 3'b000, 11'h1C, 32'h0000_0099, 1'b0, 1'b0, 32'd0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rmw_in_wr", 32'({mem_en, mem_we}), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", 32'({req_ready, rsp_valid, rsp_err, mem_en, mem_we}), 32'd0);
      chk("midrst_mwdata", mem_wdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_writes", 32'(wr_cnt - w0), 32'd0);
      chk("midrst_mem", mem[7], 32'h5566_7788);
      arb_run(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every access to the word-organised data memory and shares it between two requesters: port 0 (pipeline MEM stage) and port 1 (DMA/debug loader).
- Performs round-robin arbitration, alignment checking, and sign/zero extension for lb/lh/lw/lbu/lhu.
- Implements sb/sh as a read-modify-write so the memory only ever sees full-word writes.
- Sits between the MEM stage and a synchronous single-port SRAM with 1-cycle read latency.

Parameters:
DM_ADDRESS, 9, word-index width of the memory (2**DM_ADDRESS words)
DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  2  per-port request valid (bit p = port p)
req_ready  out  2  per-port accept; a request transfers when valid and ready are both high at a rising edge
req_we  in  2  per-port 1 = store, 0 = load
req_funct3  in  6  per-port funct3, port p at [3p+2:3p]
req_addr  in  2*(DM_ADDRESS+2)  per-port byte address; bits [1:0] give the lane, upper bits give the word index
req_wdata  in  2*DATA_W  per-port store data, right-aligned
rsp_valid  out  2  per-port one-cycle response pulse
rsp_err  out  1  response carries misalign/illegal error
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM full-word write enable
mem_addr  out  DM_ADDRESS  SRAM word index
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read is enabled

Behaviour:
- All outputs are registered.
- Reset: asynchronous. rst_n low forces state IDLE and drives every output to 0. Any in-flight access is dropped: no response, no write. last_grant resets to 1, so port 0 wins first.
- Reset mid-RMW: the partial write is not performed.
- States: IDLE, RD, RD_WAIT, WR, RESP.
- req_ready:
  - Asserted only in IDLE, and only for the granted port; it is 0 for the other port.
  - If both ports are valid, grant goes to the port != last_grant. A single valid port is always granted.
  - last_grant updates on each transfer.
- Decode at the transfer edge. Latched: port id, we, funct3, lane = addr[1:0], word index, wdata.
- Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Any other encoding is illegal.
- Misaligned:
  - half (x01) with addr[0]=1;
  - word (010) with addr[1:0]!=0.
- Illegal or misaligned access: IDLE->RESP, rsp_err=1, no mem_en. rsp_valid is high 1 cycle after the transfer edge.
- Load: IDLE->RD->RD_WAIT->RESP.
  - RD: mem_en=1, mem_we=0.
  - RD_WAIT: mem_rdata sampled, lane selected by lane (byte: lane*8; half: lane[1]*16), extended per funct3.
  - rsp_valid is high 3 cycles after the transfer edge.
- sw: IDLE->WR->RESP.
  - WR: mem_en=1, mem_we=1, mem_wdata=wdata.
  - rsp_valid is high 2 cycles after the transfer edge.
- sb/sh: IDLE->RD->RD_WAIT->WR->RESP.
  - Merge replaces only the addressed lane(s) with wdata[7:0] / wdata[15:0]. Other bytes keep the value read in RD_WAIT.
  - rsp_valid is high 4 cycles after the transfer edge.
- RESP:
  - rsp_valid[port]=1 for exactly one cycle; no backpressure.
  - rsp_rdata is valid only in that cycle.
  - Next state is IDLE. A new request can transfer at the earliest on the edge ending the first IDLE cycle.
- mem_en/mem_we are 0 in IDLE and RESP. The controller never issues a write without a completed preceding read in RMW.
- A request arriving while busy stays pending; the requester must hold valid and payload stable until ready.

Test Plan:
- Reset, mem[5]=0x8080_F081; port0 lb addr 0x14 -> rsp_valid[0] 3 cycles after transfer, rsp_rdata=0xFFFF_FF81; lbu addr 0x15 -> 0x0000_00F0; lh addr 0x16 -> 0xFFFF_8080; lhu addr 0x16 -> 0x0000_8080.
- mem[2]=0x1122_3344; port1 sb addr 0x09, wdata 0xAB -> one read then one write of 0x1122_AB44 to index 2, rsp_valid[1] 4 cycles after transfer; sh addr 0x0A wdata 0xBEEF -> 0xBEEF_AB44.
- Port0 sw addr 0x0C wdata 0xDEAD_BEEF -> single write, no read, rsp 2 cycles later; lw addr 0x0C -> 0xDEAD_BEEF.
- lw addr 0x0E, sh addr 0x03, funct3 011 load, store funct3 100 -> rsp_err=1 after 1 cycle, mem_en never high.
- Both ports valid continuously with 6 loads each -> grants alternate 0,1,0,1,…, first grant port 0, every response on the correct port bit.
- rst_n pulled low during WR of an sb -> outputs 0 immediately, mem_we never asserted for that access, no response; next request after release is granted to port 0.
